flag_unit_pipelined: RTL and testbench
======================================

Name: flag_unit_pipelined

Overview:
- Parametrised successor to the combinational zero detector.
- Computes N/Z/C/V for an ALU result using a fan-in-GROUP OR-reduction tree. Tree levels are optionally registered.
- Commits NZCV to an architectural flag register only for flag-setting ops (ADDS/SUBS/ANDS).
- Sits after the EX-stage ALU. Also provides a per-op zero output for CBZ/CBNZ resolution, whether or not the op sets flags.

Parameters:
- WIDTH, 64, result width in bits (WIDTH >= GROUP).
- GROUP, 4, OR fan-in per tree level (>= 2). L = ceil(log_GROUP(WIDTH)) levels; L = 3 at the defaults.
- PIPE, 1, 1 = register after every tree level (LAT = L); 0 = whole tree combinational, single output register (LAT = 1).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  op present this cycle
- result  in  WIDTH  ALU result
- carry_in  in  1  ALU carry-out
- ovf_in  in  1  ALU signed overflow
- set_flags  in  1  op writes NZCV
- flush  in  1  kill all in-flight ops (mispredict)
- out_valid  out  1  op completed this cycle
- zero_out  out  1  zero flag of the completing op (valid with out_valid)
- nzcv  out  4  architectural flags {N,Z,C,V}

Behaviour:
- Reset (async, active-high): all stage valid bits = 0; out_valid = 0; zero_out = 0; nzcv = 4'b0000. Stage data registers need no reset. Reset mid-operation discards every in-flight op.
- Tree:
  - Level 1 ORs consecutive GROUP-bit slices of result. Any partial last slice is zero-padded.
  - Each further level ORs GROUP outputs of the level below until one bit remains.
  - Z = NOT(final OR).
  - N = result[WIDTH-1]; C and V are the inputs carried unchanged.
- Pipeline:
  - Sideband {valid, set_flags, N, C, V} travels with the partial ORs through every stage register.
  - Stages accept a new op every cycle; there is no stall/backpressure.
- Latency: op sampled at edge k completes after edge k+LAT-1.
  - out_valid is high for exactly one cycle per op.
  - zero_out is valid in that same cycle; zero_out holds its last value when out_valid = 0.
- Commit: at the edge where a valid op leaves the last stage with set_flags = 1, nzcv <= {N,Z,C,V}. Ops with set_flags = 0 leave nzcv unchanged.
  - nzcv is the commit register itself. The new value is visible in the same cycle out_valid rises.
- Flush (synchronous, sampled at the edge):
  - Clears every stage valid bit, including the op that would complete at that edge. Its nzcv update and out_valid are suppressed.
  - in_valid on the same edge is also dropped.
  - nzcv is never modified by flush. The op already showing out_valid in the flush cycle has already committed.
- Back-to-back set_flags ops commit in order, one per cycle. No merging and no loss.
- X on result when in_valid = 0 must not propagate to nzcv or out_valid.

Test Plan:
- Defaults (LAT = 3). Reset, then in_valid = 1, result = 0, set_flags = 1, carry_in = 1, ovf_in = 0 at edge 0 -> out_valid = 1 and zero_out = 1 after edge 2; nzcv = 4'b0110. Before that, nzcv = 4'b0000.
- Walking-one sweep: result = 1<<i for i = 0..63, one op per cycle, set_flags = 1 -> zero_out = 0 for every op; N = 1 only for i = 63; 64 consecutive out_valid pulses.
- set_flags = 0 with result = 0 -> zero_out = 1, nzcv unchanged from prior value (e.g. 4'b1001 stays 4'b1001).
- Ops A (result = 0) and B (result = 5) issued on consecutive cycles. Assert flush on the edge where A would complete -> neither A nor B produces out_valid; nzcv unchanged. Next op completes normally 3 cycles after issue.
- Assert reset asynchronously mid-cycle with 3 ops in flight -> nzcv = 0 and out_valid = 0 immediately; no completions after reset release.
- PIPE = 0, WIDTH = 10, GROUP = 4 (padded tree): result = 10'h200 -> Z = 0, N = 1 one cycle later; result = 0 -> Z = 1.

Source files
------------

// File: rtl/flag_unit_pipelined_if.sv
// Bus between the EX-stage ALU and the flag unit: op inputs in, completion and
// architectural flags out.
interface flag_unit_pipelined_if #(
  parameter int WIDTH = 64
);
  // Valid-only handshake: an op is taken on every edge where in_valid = 1 and
  // there is no ready/backpressure; out_valid pulses for one cycle per op.
  logic             in_valid;
  logic [WIDTH-1:0] result;
  logic             carry_in;
  logic             ovf_in;
  logic             set_flags;
  logic             flush;
  logic             out_valid;
  logic             zero_out;
  logic [3:0]       nzcv;

  modport master (
    output in_valid, result, carry_in, ovf_in, set_flags, flush,
    input  out_valid, zero_out, nzcv
  );

  modport slave (
    input  in_valid, result, carry_in, ovf_in, set_flags, flush,
    output out_valid, zero_out, nzcv
  );
endinterface

// File: rtl/flag_unit_pipelined.sv
// NZCV flag unit: zero detect via a GROUP-ary OR tree, optionally registered
// per level, committing flags to an architectural register for flag-setting ops.
module flag_unit_pipelined #(
  parameter int WIDTH = 64,
  parameter int GROUP = 4,
  parameter int PIPE  = 1
) (
  input logic                  clk,
  input logic                  reset,
  flag_unit_pipelined_if.slave bus
);

  function automatic int calc_levels(input int w, input int g);
    int n;
    int l;
    n = w;
    l = 0;
    while (n > 1) begin
      n = (n + g - 1) / g;
      l = l + 1;
    end
    return l;
  endfunction

  localparam int L  = calc_levels(WIDTH, GROUP);
  localparam int W1 = (WIDTH + GROUP - 1) / GROUP;
  // Every level works on a PW-bit vector; bits above the live width stay zero,
  // which provides the zero padding for a partial last slice.
  localparam int PW = W1 * GROUP;

  typedef struct packed {
    logic set_flags;
    logic n;
    logic c;
    logic v;
  } side_t;

  logic [PW-1:0] lvl_in [0:L-1];
  logic [PW-1:0] lvl_or [1:L];
  logic          vld    [0:L-1];
  side_t         side   [0:L-1];

  assign lvl_in[0] = PW'(bus.result);
  assign vld[0]    = bus.in_valid;
  assign side[0]   = {bus.set_flags, bus.result[WIDTH-1], bus.carry_in, bus.ovf_in};

  for (genvar l = 1; l <= L; l++) begin : g_level
    logic [W1-1:0] part;

    for (genvar j = 0; j < W1; j++) begin : g_or
      assign part[j] = |lvl_in[l-1][j*GROUP +: GROUP];
    end
    assign lvl_or[l] = PW'(part);

    if (l < L) begin : g_stage
      if (PIPE != 0) begin : g_reg
        logic          vld_r;
        side_t         side_r;
        logic [PW-1:0] or_r;

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            vld_r <= 1'b0;
          end else begin
            vld_r <= vld[l-1] & ~bus.flush;
          end
        end

        // Payload is qualified by vld_r, so it needs no reset.
        always_ff @(posedge clk) begin
          or_r   <= lvl_or[l];
          side_r <= side[l-1];
        end

        assign vld[l]    = vld_r;
        assign side[l]   = side_r;
        assign lvl_in[l] = or_r;
      end else begin : g_comb
        assign vld[l]    = vld[l-1];
        assign side[l]   = side[l-1];
        assign lvl_in[l] = lvl_or[l];
      end
    end
  end

  logic       z_final;
  logic       commit;
  logic       out_valid_r;
  logic       zero_out_r;
  logic [3:0] nzcv_r;

  assign z_final = ~|lvl_or[L];
  assign commit  = vld[L-1] & ~bus.flush;

  // Output register doubles as the architectural NZCV register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      zero_out_r  <= 1'b0;
      nzcv_r      <= 4'b0000;
    end else begin
      out_valid_r <= commit;
      if (commit) begin
        zero_out_r <= z_final;
        if (side[L-1].set_flags) begin
          nzcv_r <= {side[L-1].n, z_final, side[L-1].c, side[L-1].v};
        end
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.zero_out  = zero_out_r;
  assign bus.nzcv      = nzcv_r;

endmodule

// File: tb/tb_flag_unit_pipelined.sv
// Bench for flag_unit_pipelined: default pipelined instance (LAT = 3) and a
// padded combinational-tree instance (WIDTH = 10, GROUP = 4, PIPE = 0, LAT = 1).
module tb_flag_unit_pipelined;

  localparam int WA    = 64;
  localparam int LAT_A = 3;
  localparam int WB    = 10;
  localparam int LAT_B = 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  flag_unit_pipelined_if #(.WIDTH(WA)) bus_a ();
  flag_unit_pipelined_if #(.WIDTH(WB)) bus_b ();

  flag_unit_pipelined #(.WIDTH(WA), .GROUP(4), .PIPE(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  flag_unit_pipelined #(.WIDTH(WB), .GROUP(4), .PIPE(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] due;
    logic        zero;
    logic        set_flags;
    logic [3:0]  nzcv;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];
  logic [3:0]    model_a;
  logic [3:0]    model_b;
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;

  typedef struct {
    logic [WA-1:0] result;
    logic          carry;
    logic          ovf;
    logic          set_flags;
    logic          exp_zero;
    logic          exp_n;
  } vec_a_t;

  typedef struct {
    logic [WB-1:0] result;
    logic          carry;
    logic          ovf;
    logic          set_flags;
    logic          exp_zero;
    logic          exp_n;
  } vec_b_t;

  vec_a_t tab_a[8];
  vec_b_t tab_b[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_a();
    exp_t e;
    logic due_now;
    due_now = 1'b0;
    if (exp_a_q.size() > 0) begin
      e = exp_a_q[0];
      due_now = (e.due == 32'(cyc));
    end
    chk("a_out_valid", 32'(bus_a.out_valid), 32'(due_now));
    if (due_now) begin
      e = exp_a_q.pop_front();
      if (e.set_flags) model_a = e.nzcv;
      chk("a_zero_out", 32'(bus_a.zero_out), 32'(e.zero));
    end
    chk("a_nzcv", 32'(bus_a.nzcv), 32'(model_a));
  endtask

  task automatic check_b();
    exp_t e;
    logic due_now;
    due_now = 1'b0;
    if (exp_b_q.size() > 0) begin
      e = exp_b_q[0];
      due_now = (e.due == 32'(cyc));
    end
    chk("b_out_valid", 32'(bus_b.out_valid), 32'(due_now));
    if (due_now) begin
      e = exp_b_q.pop_front();
      if (e.set_flags) model_b = e.nzcv;
      chk("b_zero_out", 32'(bus_b.zero_out), 32'(e.zero));
    end
    chk("b_nzcv", 32'(bus_b.nzcv), 32'(model_b));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    cyc++;
    check_a();
    check_b();
  endtask

  task automatic drive_a(input logic v, input logic [WA-1:0] r, input logic c, input logic o,
                         input logic s, input logic f, input logic ez, input logic en);
    exp_t e;
    bus_a.in_valid  = v;
    bus_a.result    = r;
    bus_a.carry_in  = c;
    bus_a.ovf_in    = o;
    bus_a.set_flags = s;
    bus_a.flush     = f;
    if (f) begin
      exp_a_q.delete();
    end else if (v) begin
      e.due       = 32'(cyc + LAT_A);
      e.zero      = ez;
      e.set_flags = s;
      e.nzcv      = {en, ez, c, o};
      exp_a_q.push_back(e);
    end
  endtask

  task automatic drive_b(input logic v, input logic [WB-1:0] r, input logic c, input logic o,
                         input logic s, input logic f, input logic ez, input logic en);
    exp_t e;
    bus_b.in_valid  = v;
    bus_b.result    = r;
    bus_b.carry_in  = c;
    bus_b.ovf_in    = o;
    bus_b.set_flags = s;
    bus_b.flush     = f;
    if (f) begin
      exp_b_q.delete();
    end else if (v) begin
      e.due       = 32'(cyc + LAT_B);
      e.zero      = ez;
      e.set_flags = s;
      e.nzcv      = {en, ez, c, o};
      exp_b_q.push_back(e);
    end
  endtask

  task automatic idle_a();
    drive_a(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_b();
    drive_b(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      idle_a();
      idle_b();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    //                result                    c     o     set   z     n
    tab_a[0] = '{64'h0,                    1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tab_a[1] = '{64'h1,                    1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tab_a[2] = '{64'h8000_0000_0000_0000,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tab_a[3] = '{64'hFFFF_FFFF_FFFF_FFFF,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tab_a[4] = '{64'h0,                    1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tab_a[5] = '{64'h0000_0001_0000_0000,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tab_a[6] = '{64'h0,                    1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tab_a[7] = '{64'h0010_0000_0000_0000,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    tab_b[0] = '{10'h200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tab_b[1] = '{10'h000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tab_b[2] = '{10'h100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tab_b[3] = '{10'h001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tab_b[4] = '{10'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tab_b[5] = '{10'h3FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tab_b[6] = '{10'h010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    model_a = 4'b0000;
    model_b = 4'b0000;
    idle_a();
    idle_b();

    // Reset state
    tick();
    chk("a_reset_zero_out", 32'(bus_a.zero_out), 32'd0);
    chk("b_reset_zero_out", 32'(bus_b.zero_out), 32'd0);
    tick();
    reset = 1'b0;

    // First op alone: nzcv must stay 0000 until it completes as 0110
    tick();
    drive_a(1'b1, tab_a[0].result, tab_a[0].carry, tab_a[0].ovf, tab_a[0].set_flags,
            1'b0, tab_a[0].exp_zero, tab_a[0].exp_n);
    idle_cycles(LAT_A + 1);

    // Remaining table vectors back to back, then an X bubble
    for (int i = 1; i < 8; i++) begin
      tick();
      drive_a(1'b1, tab_a[i].result, tab_a[i].carry, tab_a[i].ovf, tab_a[i].set_flags,
              1'b0, tab_a[i].exp_zero, tab_a[i].exp_n);
    end
    tick();
    drive_a(1'b0, 'x, 1'bx, 1'bx, 1'bx, 1'b0, 1'b0, 1'b0);
    idle_cycles(LAT_A + 1);

    // Walking-one sweep
    for (int i = 0; i < WA; i++) begin
      tick();
      drive_a(1'b1, 64'd1 << i, 1'(i % 2), 1'b0, 1'b1, 1'b0, 1'b0, 1'(i == WA - 1));
    end
    idle_cycles(LAT_A + 1);

    // set_flags = 0 leaves 1001 in place
    tick();
    drive_a(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    drive_a(1'b1, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles(LAT_A + 1);

    // Flush: E completes in the flush cycle, A/B in flight and C on the same edge die
    tick();
    drive_a(1'b1, 64'h4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive_a(1'b1, 64'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive_a(1'b1, 64'h8000_0000_0000_0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_cycles(LAT_A + 2);

    // Combinational padded tree, one-cycle latency
    for (int i = 0; i < 7; i++) begin
      tick();
      idle_a();
      drive_b(1'b1, tab_b[i].result, tab_b[i].carry, tab_b[i].ovf, tab_b[i].set_flags,
              1'b0, tab_b[i].exp_zero, tab_b[i].exp_n);
    end
    tick();
    drive_b(1'b1, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive_b(1'b1, 10'h200, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_cycles(LAT_B + 2);

    // Asynchronous reset with three ops in flight
    tick();
    drive_a(1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    drive_a(1'b1, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive_a(1'b1, 64'h7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_async_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_async_nzcv", 32'(bus_a.nzcv), 32'd0);
    chk("rst_async_zero_out", 32'(bus_a.zero_out), 32'd0);
    chk("rst_async_b_nzcv", 32'(bus_b.nzcv), 32'd0);
    exp_a_q.delete();
    exp_b_q.delete();
    model_a = 4'b0000;
    model_b = 4'b0000;
    idle_a();
    idle_b();
    tick();
    #3;
    reset = 1'b0;
    idle_cycles(LAT_A + 3);

    // Drain with a bounded budget
    for (int k = 0; k < 20 && (exp_a_q.size() > 0 || exp_b_q.size() > 0); k++) begin
      tick();
    end
    chk("drain_pending", 32'(exp_a_q.size() + exp_b_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
